// File: rtl/affine_io_sequencer.sv
// Operator front end for the affine engine: debounced handshake protocol captures x then y,
// starts the engine, then shows x' and y' on the LEDs in turn.
module affine_io_sequencer #(
  parameter int DATA_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  handshake,
  input  logic [DATA_WIDTH-1:0] sw_data,
  output logic                  eng_start,
  output logic [DATA_WIDTH-1:0] eng_x,
  output logic [DATA_WIDTH-1:0] eng_y,
  input  logic                  eng_done,
  input  logic [DATA_WIDTH-1:0] eng_xr,
  input  logic [DATA_WIDTH-1:0] eng_yr,
  output logic [DATA_WIDTH-1:0] led,
  output logic                  err,
  output logic [2:0]            dbg_state
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TM_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] TM_MAX = TM_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    X_WAIT  = 3'd0,
    X_REL   = 3'd1,
    Y_WAIT  = 3'd2,
    Y_REL   = 3'd3,
    COMPUTE = 3'd4,
    SHOW_X  = 3'd5,
    SHOW_Y  = 3'd6
  } state_t;

  state_t                  state;
  logic                    hs_s1, hs_s2, hs_db;
  logic                    rise, fall;
  logic [DB_W-1:0]         db_cnt;
  logic [DATA_WIDTH-1:0]   sw_s1, sw_sync;
  logic [TM_W-1:0]         timer;
  logic [DATA_WIDTH-1:0]   yr_q;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_s1   <= 1'b0;
      hs_s2   <= 1'b0;
      sw_s1   <= '0;
      sw_sync <= '0;
    end else begin
      hs_s1   <= handshake;
      hs_s2   <= hs_s1;
      sw_s1   <= sw_data;
      sw_sync <= sw_s1;
    end
  end

  // hs_db flips only after DEBOUNCE_CYCLES consecutive synced samples disagree with it;
  // rise/fall pulse in the cycle after the flip.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_db  <= 1'b0;
      db_cnt <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (hs_s2 == hs_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        hs_db  <= hs_s2;
        db_cnt <= '0;
        rise   <= hs_s2;
        fall   <= ~hs_s2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Engine protocol: eng_start is a one-cycle request, eng_x/eng_y stay stable until the
  // engine answers with a one-cycle eng_done (results valid that cycle only) or we time out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= X_WAIT;
      eng_start <= 1'b0;
      eng_x     <= '0;
      eng_y     <= '0;
      led       <= '0;
      err       <= 1'b0;
      timer     <= '0;
      yr_q      <= '0;
    end else begin
      eng_start <= 1'b0;
      case (state)
        X_WAIT: if (rise) begin
          eng_x <= sw_sync;
          err   <= 1'b0;
          state <= X_REL;
        end
        X_REL: if (fall) state <= Y_WAIT;
        Y_WAIT: if (rise) begin
          eng_y <= sw_sync;
          state <= Y_REL;
        end
        Y_REL: if (fall) begin
          eng_start <= 1'b1;
          timer     <= '0;
          state     <= COMPUTE;
        end
        COMPUTE: begin
          // A done arriving on the last timer cycle wins over the timeout.
          if (eng_done) begin
            yr_q  <= eng_yr;
            led   <= eng_xr;
            state <= SHOW_X;
          end else if (timer == TM_MAX) begin
            err   <= 1'b1;
            state <= X_WAIT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SHOW_X: if (hs_db) begin
          led   <= yr_q;
          state <= SHOW_Y;
        end
        SHOW_Y: if (!hs_db) state <= X_WAIT;
        default: state <= X_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_affine_io_sequencer.sv
// Directed bench for affine_io_sequencer with a stub affine engine answering after a
// programmable delay.
module tb_affine_io_sequencer;

  localparam logic [2:0] S_XW = 3'd0, S_XR = 3'd1, S_YW = 3'd2, S_YR = 3'd3,
                         S_CP = 3'd4, S_SX = 3'd5, S_SY = 3'd6;

  logic       clk = 1'b0;
  logic       reset, handshake, eng_start, eng_done, err;
  logic [7:0] sw_data, eng_x, eng_y, eng_xr, eng_yr, led;
  logic [2:0] dbg_state;

  int checks = 0, errors = 0, start_cnt = 0;
  int stub_cnt = 0, stub_delay = 5;
  bit stub_en = 1'b1;

  always #10 clk = ~clk;

  affine_io_sequencer #(.DATA_WIDTH(8), .DEBOUNCE_CYCLES(16), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .reset(reset), .handshake(handshake), .sw_data(sw_data),
    .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y), .eng_done(eng_done),
    .eng_xr(eng_xr), .eng_yr(eng_yr), .led(led), .err(err), .dbg_state(dbg_state)
  );

  // Stub engine: not tied to the DUT reset so a late done can follow a mid-compute reset.
  function automatic logic [7:0] stub_xr(input logic signed [7:0] x, input logic signed [7:0] y);
    int t;
    t = 4 * int'(x) - 7 * int'(y) + 40;
    return 8'(t >>> 3);
  endfunction

  function automatic logic [7:0] stub_yr(input logic signed [7:0] x, input logic signed [7:0] y);
    int t;
    t = -7 * int'(x) + 6 * int'(y) + 96;
    return 8'(t >>> 3);
  endfunction

  assign eng_xr   = stub_xr(eng_x, eng_y);
  assign eng_yr   = stub_yr(eng_x, eng_y);
  assign eng_done = (stub_cnt == 1);

  always @(posedge clk) begin
    if (eng_start) start_cnt <= start_cnt + 1;
    if (eng_start && stub_en) stub_cnt <= stub_delay;
    else if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
  end

  task automatic hs_step(input logic lvl, input logic [7:0] d);
    @(negedge clk);
    sw_data   = d;
    handshake = lvl;
    repeat (50) @(negedge clk);
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (eng_start) seen = 1'b1;
    end
  endtask

  task automatic run_full(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] exr, input logic [7:0] eyr);
    int s0;
    logic [7:0] led0;
    s0   = start_cnt;
    led0 = led;
    hs_step(1'b1, x);
    checks++; if (dbg_state !== S_XR) begin errors++; $display("FAIL %s x_rel_state got %0d exp %0d", tag, dbg_state, S_XR); end
    checks++; if (eng_x !== x) begin errors++; $display("FAIL %s eng_x got %h exp %h", tag, eng_x, x); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL %s err_x got %b exp 0", tag, err); end
    hs_step(1'b0, x);
    checks++; if (dbg_state !== S_YW) begin errors++; $display("FAIL %s y_wait_state got %0d exp %0d", tag, dbg_state, S_YW); end
    hs_step(1'b1, y);
    checks++; if (dbg_state !== S_YR) begin errors++; $display("FAIL %s y_rel_state got %0d exp %0d", tag, dbg_state, S_YR); end
    checks++; if (eng_y !== y) begin errors++; $display("FAIL %s eng_y got %h exp %h", tag, eng_y, y); end
    checks++; if (led !== led0) begin errors++; $display("FAIL %s led_held got %h exp %h", tag, led, led0); end
    hs_step(1'b0, y);
    checks++; if (dbg_state !== S_SX) begin errors++; $display("FAIL %s show_x_state got %0d exp %0d", tag, dbg_state, S_SX); end
    checks++; if (led !== exr) begin errors++; $display("FAIL %s led_xr got %h exp %h", tag, led, exr); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL %s start_pulses got %0d exp 1", tag, start_cnt - s0); end
    checks++; if (eng_x !== x || eng_y !== y) begin errors++; $display("FAIL %s operands_held got %h/%h exp %h/%h", tag, eng_x, eng_y, x, y); end
    hs_step(1'b1, y);
    checks++; if (dbg_state !== S_SY) begin errors++; $display("FAIL %s show_y_state got %0d exp %0d", tag, dbg_state, S_SY); end
    checks++; if (led !== eyr) begin errors++; $display("FAIL %s led_yr got %h exp %h", tag, led, eyr); end
    hs_step(1'b0, y);
    checks++; if (dbg_state !== S_XW) begin errors++; $display("FAIL %s back_x_wait got %0d exp %0d", tag, dbg_state, S_XW); end
    checks++; if (led !== eyr) begin errors++; $display("FAIL %s led_hold_yr got %h exp %h", tag, led, eyr); end
  endtask

  task automatic test_reset();
    reset = 1'b1; handshake = 1'b0; sw_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (dbg_state !== S_XW) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, S_XW); end
    checks++; if (led !== 8'h00 || err !== 1'b0) begin errors++; $display("FAIL reset_led_err got %h/%b exp 00/0", led, err); end
    checks++; if (eng_x !== 8'h00 || eng_y !== 8'h00 || eng_start !== 1'b0) begin errors++; $display("FAIL reset_eng got %h/%h/%b exp 00/00/0", eng_x, eng_y, eng_start); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (dbg_state !== S_XW) begin errors++; $display("FAIL reset_release_state got %0d exp %0d", dbg_state, S_XW); end
  endtask

  // x=10,y=20: xr=floor(-7.5)=-8, yr=floor(18.25)=18
  task automatic test_basic();
    run_full("basic", 8'd10, 8'd20, 8'hF8, 8'd18);
  endtask

  // x=-128,y=127: xr=floor(-170.125)=-171 -> 0x55, yr=floor(219.25)=219 -> 0xDB
  task automatic test_extremes();
    run_full("extremes", 8'h80, 8'h7F, 8'h55, 8'hDB);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL extremes_err got %b exp 0", err); end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    sw_data = 8'h55; handshake = 1'b1;
    repeat (5) @(negedge clk);
    handshake = 1'b0;
    repeat (50) @(negedge clk);
    checks++; if (dbg_state !== S_XW) begin errors++; $display("FAIL glitch_state got %0d exp %0d", dbg_state, S_XW); end
    checks++; if (eng_x !== 8'h80) begin errors++; $display("FAIL glitch_eng_x got %h exp 80", eng_x); end
  endtask

  // x=40,y=-40: xr=60 (0x3C), yr=-53 (0xCB); handshake already high when done arrives.
  task automatic test_hs_hold();
    bit seen;
    int n;
    hs_step(1'b1, 8'd40);
    hs_step(1'b0, 8'd40);
    hs_step(1'b1, 8'hD8);
    stub_delay = 40;
    @(negedge clk);
    handshake = 1'b0;
    wait_start(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL hold_start got %b exp 1", seen); end
    @(negedge clk);
    handshake = 1'b1;
    n = 0;
    while (!eng_done && n < 100) begin @(negedge clk); n++; end
    checks++; if (eng_done !== 1'b1 || dbg_state !== S_CP) begin errors++; $display("FAIL hold_done_in_compute got %b/%0d exp 1/%0d", eng_done, dbg_state, S_CP); end
    @(negedge clk);
    checks++; if (led !== 8'h3C || dbg_state !== S_SX) begin errors++; $display("FAIL hold_show_x got %h/%0d exp 3c/%0d", led, dbg_state, S_SX); end
    @(negedge clk);
    checks++; if (led !== 8'hCB || dbg_state !== S_SY) begin errors++; $display("FAIL hold_show_y got %h/%0d exp cb/%0d", led, dbg_state, S_SY); end
    stub_delay = 5;
    hs_step(1'b0, 8'hD8);
    checks++; if (dbg_state !== S_XW) begin errors++; $display("FAIL hold_back_x_wait got %0d exp %0d", dbg_state, S_XW); end
  endtask

  // Second run: x=-8,y=16 gives xr=-13 (0xF3), yr=31 (0x1F).
  task automatic test_timeout();
    bit seen;
    int n;
    stub_en = 1'b0;
    hs_step(1'b1, 8'd3);
    hs_step(1'b0, 8'd3);
    hs_step(1'b1, 8'd4);
    @(negedge clk);
    handshake = 1'b0;
    wait_start(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL timeout_start got %b exp 1", seen); end
    n = 0;
    while (err !== 1'b1 && n < 1200) begin @(negedge clk); n++; end
    checks++; if (n !== 1024) begin errors++; $display("FAIL timeout_latency got %0d exp 1024", n); end
    checks++; if (dbg_state !== S_XW) begin errors++; $display("FAIL timeout_state got %0d exp %0d", dbg_state, S_XW); end
    checks++; if (led !== 8'hCB) begin errors++; $display("FAIL timeout_led got %h exp cb", led); end
    stub_en = 1'b1;
    hs_step(1'b1, 8'hF8);
    checks++; if (err !== 1'b0 || dbg_state !== S_XR) begin errors++; $display("FAIL timeout_clear got %b/%0d exp 0/%0d", err, dbg_state, S_XR); end
    hs_step(1'b0, 8'hF8);
    hs_step(1'b1, 8'd16);
    hs_step(1'b0, 8'd16);
    checks++; if (led !== 8'hF3) begin errors++; $display("FAIL timeout_rerun_xr got %h exp f3", led); end
    hs_step(1'b1, 8'd16);
    checks++; if (led !== 8'h1F) begin errors++; $display("FAIL timeout_rerun_yr got %h exp 1f", led); end
    hs_step(1'b0, 8'd16);
  endtask

  task automatic test_reset_compute();
    bit seen;
    int s0;
    hs_step(1'b1, 8'd1);
    hs_step(1'b0, 8'd1);
    hs_step(1'b1, 8'd2);
    @(negedge clk);
    handshake = 1'b0;
    wait_start(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_start got %b exp 1", seen); end
    repeat (2) @(negedge clk);
    s0 = start_cnt;
    reset = 1'b1;
    #1;
    checks++; if (led !== 8'h00 || err !== 1'b0) begin errors++; $display("FAIL rst_led_err got %h/%b exp 00/0", led, err); end
    checks++; if (dbg_state !== S_XW || eng_x !== 8'h00 || eng_start !== 1'b0) begin errors++; $display("FAIL rst_regs got %0d/%h/%b exp 0/00/0", dbg_state, eng_x, eng_start); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (start_cnt !== s0) begin errors++; $display("FAIL rst_no_start got %0d exp %0d", start_cnt, s0); end
    checks++; if (dbg_state !== S_XW || led !== 8'h00) begin errors++; $display("FAIL rst_late_done got %0d/%h exp 0/00", dbg_state, led); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_glitch();
    test_hs_hold();
    test_timeout();
    test_reset_compute();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
